// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// pipe_ctrl_pkg: FSM states, register-address width and stage-control bundle for pipe_ctrl.
// Rev 1.0
package pipe_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
    logic mem_err;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_DEFAULT = '{
    pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b0, mem_err: 1'b0
  };

  // Front of the pipe frozen; MEM/WB keeps advancing but receives bubbles.
  localparam stage_ctrl_t CTRL_MEM_STALL = '{
    pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b1, mem_err: 1'b0
  };

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// hazard_detect: combinational load-use compare between the ID sources and the EX load target.
// Rev 1.0
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_is_load_i,
  output logic              load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_used_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_rs2_used_i && (id_rs2_i == ex_rd_i);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use_o = ex_is_load_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// pipe_ctrl: stall/flush controller for the five-stage pipeline with memory timeout and stall counter.
// Rev 1.0
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_is_load_i,
  input  logic              ex_redirect_i,
  input  logic              mem_req_i,
  input  logic              mem_ack_i,
  output logic              pc_en_o,
  output logic              if_id_en_o,
  output logic              id_ex_en_o,
  output logic              ex_mem_en_o,
  output logic              mem_wb_en_o,
  output logic              if_id_flush_o,
  output logic              id_ex_flush_o,
  output logic              mem_wb_flush_o,
  output logic              mem_err_o,
  output logic [CW-1:0]     stall_cnt_o
);

  localparam int unsigned WCW = $clog2(TIMEOUT);

  // The controller never touches datapath values; W only has to agree with the core.
  if (W != XLEN) begin : g_w_mismatch
  end

  state_e          state_q, state_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
  stage_ctrl_t     ctrl;
  logic            load_use;
  logic            wait_last;

  hazard_detect u_hazard_detect (
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .ex_rd_i       (ex_rd_i),
    .ex_is_load_i  (ex_is_load_i),
    .load_use_o    (load_use)
  );

  assign wait_last = (wait_cnt_q == WCW'(TIMEOUT - 1));

  always_comb begin
    ctrl       = CTRL_DEFAULT;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_req_i && !mem_ack_i) begin
          ctrl       = CTRL_MEM_STALL;
          state_d    = MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end else if (ex_redirect_i) begin
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end else if (load_use) begin
          ctrl.pc_en       = 1'b0;
          ctrl.if_id_en    = 1'b0;
          ctrl.id_ex_flush = 1'b1;
        end
      end
      MEM_WAIT: begin
        // An ack wins even on the cycle that would otherwise time out.
        if (mem_ack_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          ctrl = CTRL_MEM_STALL;
          if (wait_last) begin
            state_d    = ERR;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
          end
        end
      end
      ERR: begin
        ctrl.mem_err      = 1'b1;
        ctrl.mem_wb_flush = 1'b1;
        state_d           = RUN;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!ctrl.pc_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pc_en_o        = ctrl.pc_en;
  assign if_id_en_o     = ctrl.if_id_en;
  assign id_ex_en_o     = ctrl.id_ex_en;
  assign ex_mem_en_o    = ctrl.ex_mem_en;
  assign mem_wb_en_o    = ctrl.mem_wb_en;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_flush_o  = ctrl.id_ex_flush;
  assign mem_wb_flush_o = ctrl.mem_wb_flush;
  assign mem_err_o      = ctrl.mem_err;
  assign stall_cnt_o    = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// tb_pipe_ctrl: directed vector table plus multi-cycle sequences for pipe_ctrl (CW=4, TIMEOUT=16).
module tb_pipe_ctrl;

  localparam int CW = 4;

  // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, mem_wb_flush, mem_err}
  localparam logic [8:0] B_DEF = 9'b11111_000_0;
  localparam logic [8:0] B_LU  = 9'b00111_010_0;
  localparam logic [8:0] B_RD  = 9'b11111_110_0;
  localparam logic [8:0] B_MS  = 9'b00001_001_0;
  localparam logic [8:0] B_ERR = 9'b11111_001_1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [4:0]    id_rs1_i, id_rs2_i, ex_rd_i;
  logic          id_rs1_used_i, id_rs2_used_i, ex_is_load_i, ex_redirect_i;
  logic          mem_req_i, mem_ack_i;
  logic          pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
  logic          if_id_flush_o, id_ex_flush_o, mem_wb_flush_o, mem_err_o;
  logic [CW-1:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  pipe_ctrl #(.W(32), .TIMEOUT(16), .CW(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_rd_i(ex_rd_i), .ex_is_load_i(ex_is_load_i), .ex_redirect_i(ex_redirect_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_en_o(pc_en_o), .if_id_en_o(if_id_en_o), .id_ex_en_o(id_ex_en_o),
    .ex_mem_en_o(ex_mem_en_o), .mem_wb_en_o(mem_wb_en_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
    .mem_wb_flush_o(mem_wb_flush_o), .mem_err_o(mem_err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       redir;
    logic       req;
    logic       ack;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [8:0] outs();
    return {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
            if_id_flush_o, id_ex_flush_o, mem_wb_flush_o, mem_err_o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
    ex_rd_i = 5'd0; ex_is_load_i = 1'b0; ex_redirect_i = 1'b0;
    mem_req_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic set_lu();
    ex_is_load_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_used_i = 1'b1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #2;
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    int err_at;
    int stalls;

    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, B_DEF};
    vecs[1]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, B_LU};
    vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, B_DEF};
    vecs[3]  = '{5'd0, 5'd5, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, B_DEF};
    vecs[4]  = '{5'd7, 5'd3, 1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, B_LU};
    vecs[5]  = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, B_DEF};
    vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, B_RD};
    vecs[7]  = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, B_RD};
    vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, B_MS};
    vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, B_DEF};
    vecs[10] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0, B_MS};
    vecs[11] = '{5'd0, 5'd5, 1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 1'b1, 1'b1, B_RD};
    vecs[12] = '{5'd9, 5'd9, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, B_DEF};
    vecs[13] = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, B_DEF};

    idle();
    rst_ni = 1'b0;
    #1;
    chk("reset_outs", 32'(outs()), 32'(B_DEF));
    chk("reset_stall_cnt", 32'(stall_cnt_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    tick();

    // Zero-latency control decode from RUN, one vector per reset.
    for (int i = 0; i < 14; i++) begin
      id_rs1_i = vecs[i].rs1; id_rs2_i = vecs[i].rs2;
      id_rs1_used_i = vecs[i].u1; id_rs2_used_i = vecs[i].u2;
      ex_rd_i = vecs[i].rd; ex_is_load_i = vecs[i].ld; ex_redirect_i = vecs[i].redir;
      mem_req_i = vecs[i].req; mem_ack_i = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      tick();
      idle();
      do_reset();
    end

    // Load-use costs exactly one bubble; redirect beats it without stalling.
    set_lu();
    #1;
    chk("lu_outs", 32'(outs()), 32'(B_LU));
    tick();
    idle();
    #1;
    chk("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);
    chk("lu_released", 32'(outs()), 32'(B_DEF));
    set_lu();
    ex_redirect_i = 1'b1;
    #1;
    chk("redir_lu_outs", 32'(outs()), 32'(B_RD));
    tick();
    idle();
    #1;
    chk("redir_stall_cnt", 32'(stall_cnt_o), 32'd1);

    // Ack three cycles after the request: three stall cycles.
    do_reset();
    mem_req_i = 1'b1;
    #1;
    chk("mw_c0", 32'(outs()), 32'(B_MS));
    tick();
    chk("mw_c1", 32'(outs()), 32'(B_MS));
    tick();
    chk("mw_c2", 32'(outs()), 32'(B_MS));
    tick();
    mem_ack_i = 1'b1;
    #1;
    chk("mw_ack", 32'(outs()), 32'(B_DEF));
    tick();
    idle();
    #1;
    chk("mw_stall_cnt", 32'(stall_cnt_o), 32'd3);
    chk("mw_back_run", 32'(outs()), 32'(B_DEF));

    // No ack: timeout after 16 stall cycles, one-cycle error pulse.
    do_reset();
    mem_req_i = 1'b1;
    err_at = -1;
    stalls = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_err_o) begin
        err_at = c;
        break;
      end
      if (!pc_en_o) stalls++;
      tick();
    end
    chk("to_err_cycle", 32'(err_at), 32'd16);
    chk("to_stall_cycles", 32'(stalls), 32'd16);
    chk("to_err_outs", 32'(outs()), 32'(B_ERR));
    idle();
    tick();
    chk("to_after_err", 32'(outs()), 32'(B_DEF));
    chk("to_stall_sat", 32'(stall_cnt_o), 32'd15);

    // Ack on the would-be timeout cycle.
    do_reset();
    mem_req_i = 1'b1;
    repeat (15) tick();
    #1;
    chk("ackto_pre", 32'(outs()), 32'(B_MS));
    mem_ack_i = 1'b1;
    #1;
    chk("ackto_ack", 32'(outs()), 32'(B_DEF));
    tick();
    idle();
    #1;
    chk("ackto_no_err", 32'(outs()), 32'(B_DEF));
    chk("ackto_stall_cnt", 32'(stall_cnt_o), 32'd15);

    // Asynchronous reset in the middle of MEM_WAIT.
    do_reset();
    mem_req_i = 1'b1;
    repeat (3) tick();
    #1;
    chk("rst_mw_pre", 32'(outs()), 32'(B_MS));
    mem_req_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("rst_mw_outs", 32'(outs()), 32'(B_DEF));
    chk("rst_mw_stall_cnt", 32'(stall_cnt_o), 32'd0);
    rst_ni = 1'b1;
    tick();
    chk("rst_mw_after", 32'(outs()), 32'(B_DEF));
    chk("rst_mw_cnt_after", 32'(stall_cnt_o), 32'd0);

    // 2^CW+5 stall cycles: counter saturates at 15.
    do_reset();
    set_lu();
    repeat (14) tick();
    chk("sat_cnt14", 32'(stall_cnt_o), 32'd14);
    repeat (7) tick();
    chk("sat_cnt15", 32'(stall_cnt_o), 32'd15);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and stall controller for the five-stage RV32 core. Generates per-stage enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers from load-use hazards, EX-stage redirects and data-memory wait states. It also detects data-memory timeouts and keeps a saturating stall counter. It sits beside the datapath and drives every pipeline register's control inputs.

## Interface
- W, 32: datapath width (package consistency only)
- TIMEOUT, 16: maximum cycles to wait for mem_ack_i, ≥2
- CW, 16: stall counter width
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- id_rs1_i, id_rs2_i  in  5 each  source registers of the instruction in ID
- id_rs1_used_i, id_rs2_used_i  in  1 each  the ID instruction reads rs1 / rs2
- ex_rd_i  in  5  destination of the instruction in EX
- ex_is_load_i  in  1  the EX instruction is a load
- ex_redirect_i  in  1  EX resolved a taken branch or jump (PC redirect)
- mem_req_i  in  1  MEM stage issues a load/store this cycle
- mem_ack_i  in  1  data memory completes the access this cycle
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  stage advance enables
- if_id_flush_o, id_ex_flush_o, mem_wb_flush_o  out  1 each  load a bubble (all-zero) into the register. Flush overrides enable at the register.
- mem_err_o  out  1  one-cycle pulse on memory timeout
- stall_cnt_o  out  CW  cycles with pc_en_o=0, saturating

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN.
- Defaults: all enables 1, all flushes 0, mem_err_o 0.
- RUN, evaluated in priority order:
  1. Memory stall. If mem_req_i && !mem_ack_i: pc/if_id/id_ex/ex_mem enables 0, mem_wb_flush_o=1; next state MEM_WAIT with wait_cnt=1. A same-cycle ack causes no stall.
  2. Redirect. If ex_redirect_i: if_id_flush_o=1, id_ex_flush_o=1. Redirect beats load-use.
  3. Load-use. If ex_is_load_i && ex_rd_i≠0 && ((id_rs1_used_i && id_rs1_i==ex_rd_i) || (id_rs2_used_i && id_rs2_i==ex_rd_i)): pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1.
- MEM_WAIT: same outputs as memory stall; inputs 2 and 3 are ignored.
  - mem_ack_i → RUN, all enables 1 that cycle (the access completes and MEM/WB captures it).
  - Else if wait_cnt==TIMEOUT-1 → ERR.
  - Else wait_cnt+1.
- ERR, one cycle: mem_err_o=1, mem_wb_flush_o=1, other enables 1 (the faulting access is dropped); next state RUN.
- stall_cnt_o increments when pc_en_o==0 and holds at 2^CW-1.
- x0 is never a hazard source.

## Timing
- All enable, flush and mem_err_o outputs are combinational from the current state and the inputs (zero latency). State, wait_cnt and stall_cnt update on the rising edge.
- Reset values: state RUN, wait_cnt 0, stall_cnt_o 0, mem_err_o 0. Enables and flushes follow RUN rules during reset.
- Reset asserted in MEM_WAIT or ERR returns immediately to RUN. The pending access is abandoned.
- A load-use hazard costs exactly 1 bubble cycle. A redirect costs 2 flushed slots. A memory wait of N cycles costs N stall cycles.
- If mem_ack_i is asserted in the cycle the state would enter ERR, the ack wins and the state goes to RUN.

## Structure
- pipe_ctrl_pkg holds the state enum (RUN, MEM_WAIT, ERR), the register-address width constant (5) and a typedef for the stage-control bundle.
- One combinational sub-module, hazard_detect, computes the load-use compare. The FSM, wait counter and stall counter stay in pipe_ctrl.

## Test plan
- ex_is_load_i=1, ex_rd_i=5, id_rs2_i=5, id_rs2_used_i=1 → one cycle of pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1; stall_cnt_o 0→1. Repeat with ex_rd_i=0 → no stall.
- Redirect together with a load-use match → only if_id_flush_o=id_ex_flush_o=1; pc_en_o=1; stall_cnt_o unchanged.
- mem_req_i=1 with mem_ack_i arriving 3 cycles later → MEM_WAIT for 3 cycles with mem_wb_flush_o=1 and the front enables 0, then RUN; stall_cnt_o=3.
- mem_req_i=1 and no ack, TIMEOUT=16 → ERR after 16 stall cycles; mem_err_o pulses exactly 1 cycle, then RUN.
- Ack on the timeout cycle → RUN, no mem_err_o. rst_ni pulsed mid-MEM_WAIT → RUN, stall_cnt_o=0, all enables 1.
- Force 2^CW+5 stall cycles with CW=4 → stall_cnt_o holds at 15.
